// File: rtl/uart_tx_ctrl_pkg.sv
// rtl/uart_tx_ctrl_pkg.sv - shared UART frame constants and FSM state encoding
package uart_tx_ctrl_pkg;

  // Data bits per frame; also used by the receive side.
  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_ctrl_baud_tick_gen.sv
// rtl/uart_tx_ctrl_baud_tick_gen.sv - bit-period counter with sync clear and terminal tick
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == TERM);

  // Next count: clear wins, otherwise count while enabled and wrap on the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer (start, data, parity, stop)
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 tick;

  assign tx_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign accept   = tx_valid && tx_ready;
  assign tx       = tx_q;
  assign done     = done_q;

  // The divider restarts on accept so the start bit gets a full period.
  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (busy),
    .tick   (tick)
  );

  // Frame sequencing; the line value is derived from the next state so tx is registered.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d  = tx_data;
          parity_d = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
          idx_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          idx_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl across four frame formats
module tb_uart_tx_ctrl;

  localparam int C = 10;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data [4];
  logic [3:0] tx_valid;
  logic [3:0] tx_ready;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] done;

  int checks;
  int errors;

  // Unit 0: plain; 1: even parity; 2: odd parity; 3: two stop bits.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_ctrl #(
      .CLKS_PER_BIT (C),
      .PARITY_EN    ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD   ((g == 2) ? 1 : 0),
      .STOP_BITS    ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data[g]),
      .tx_valid (tx_valid[g]),
      .tx_ready (tx_ready[g]),
      .tx       (tx[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cfg_pe(input int u);
    return (u == 1 || u == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_odd(input int u);
    return (u == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_stop(input int u);
    return (u == 3) ? 2 : 1;
  endfunction

  // Line level of frame bit k: start, data LSB first, parity making the one-count even/odd, stops.
  function automatic logic exp_bit(input logic [7:0] b, input int k, input int pe, input int odd);
    int ones;
    ones = $countones(b);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (pe != 0 && k == 9) return (odd != 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  // Called at the falling edge right after the accepting edge; ends on the done cycle.
  task automatic frame_check(input int u, input logic [7:0] b, input bit noise);
    int f;
    int fc;
    f  = 9 + cfg_pe(u) + cfg_stop(u);
    fc = f * C;
    for (int j = 0; j <= fc; j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("tx u%0d b%02h j%0d", u, b, j), tx[u],
          (j < fc) ? exp_bit(b, j / C, cfg_pe(u), cfg_odd(u)) : 1'b1);
      chk($sformatf("done u%0d j%0d", u, j), done[u], (j == fc));
      chk($sformatf("busy u%0d j%0d", u, j), busy[u], (j < fc));
      chk($sformatf("ready u%0d j%0d", u, j), tx_ready[u], (j == fc));
      if (noise) begin
        if (j < fc) begin
          tx_valid[u] = 1'($urandom);
          tx_data[u]  = 8'hFF;
        end else begin
          tx_valid[u] = 1'b0;
        end
      end
    end
  endtask

  task automatic send(input int u, input logic [7:0] b, input bit noise);
    @(negedge clk);
    chk($sformatf("ready_pre u%0d", u), tx_ready[u], 1'b1);
    tx_data[u]  = b;
    tx_valid[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid[u] = 1'b0;
    frame_check(u, b, noise);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    tx_valid = 4'h0;
    for (int u = 0; u < 4; u++) tx_data[u] = 8'h00;

    // Held in reset, requests must be ignored and outputs stay idle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tx_valid = ~tx_valid;
      for (int u = 0; u < 4; u++) tx_data[u] = 8'($urandom);
      @(negedge clk);
      chk("rst_tx", tx, 4'hF);
      chk("rst_ready", tx_ready, 4'hF);
      chk("rst_busy", busy, 4'h0);
      chk("rst_done", done, 4'h0);
    end
    tx_valid = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_tx", tx, 4'hF);
    chk("post_rst_busy", busy, 4'h0);

    // Directed formats.
    send(0, 8'hA5, 1'b0);
    send(1, 8'h07, 1'b0);
    send(2, 8'h07, 1'b0);
    send(3, 8'h07, 1'b0);

    // Random bytes over every format.
    for (int i = 0; i < 6; i++) begin
      for (int u = 0; u < 4; u++) send(u, 8'($urandom), 1'b0);
    end

    // Back-to-back: valid held across the done cycle, data changed mid-frame.
    @(negedge clk);
    tx_data[0]  = 8'h55;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_data[0] = 8'hAA;
    frame_check(0, 8'h55, 1'b0);
    @(posedge clk);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    frame_check(0, 8'hAA, 1'b0);

    // Reset during data bit 3 returns the line high at once.
    @(negedge clk);
    tx_data[0]  = 8'h00;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (4 * C + 4) @(negedge clk);
    chk("mid_bit3_tx", tx[0], 1'b0);
    chk("mid_bit3_busy", busy[0], 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("abort_tx", tx[0], 1'b1);
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_ready", tx_ready[0], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    send(0, 8'h3C, 1'b0);

    // Requests and data changes while busy must not disturb the frame.
    send(0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 3)), 8'($urandom), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
